i2c_slave_regfile: RTL
======================

# i2c_slave_regfile

Parametrised I2C target with a built-in register file, the successor to the empty `rtl_top` I2C slave shell. It decodes START, repeated START and STOP, matches a configurable 7-bit address, and supports pointer-addressed, auto-incrementing byte writes and reads. A host-side port lets on-chip logic read and write the same registers. It sits directly under `rtl_top`, between the `scl`/`sda` pins and system logic.

## Interface
- `SLAVE_ADDR`, default 7'h42: 7-bit target address that the block ACKs.
- `REG_DEPTH`, default 16: number of 8-bit registers, 2..256. `PTR_W = $clog2(REG_DEPTH)`.
- `SYNC_STAGES`, default 2: input synchroniser depth on `scl`/`sda`, minimum 2.
- `clk` input 1: system clock, the only clock. `scl` is sampled, never used as a clock.
- `nRst` input 1: reset, synchronous, active-low.
- `scl` input 1: I2C clock pin. Stretching is not supported.
- `sda` inout 1: I2C data pin, open-drain. Driven 1'b0 or 1'bz, never 1'b1.
- `host_we` input 1: host write strobe.
- `host_addr` input PTR_W: host register index.
- `host_wdata` input 8: host write data.
- `host_rdata` output 8: combinational read of `regs[host_addr]`.
- `wr_strobe` output 1: one-cycle pulse when an I2C data byte is committed.
- `wr_addr` output PTR_W: register index of the committed byte. Valid with `wr_strobe`.
- `wr_data` output 8: committed byte. Valid with `wr_strobe`.
- `busy` output 1: high from an address-matched ACK until STOP or NACK-termination.

## Operation
- **Input conditioning:** `scl` and `sda` pass through `SYNC_STAGES` flops, then a 1-flop edge detector. This produces `scl_rise`, `scl_fall`, START (`sda` falls while `scl`=1) and STOP (`sda` rises while `scl`=1).
- **FSM states:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- **Bit sampling:** bits are sampled on `scl_rise`, MSB first, with a 3-bit bit counter. SDA drive changes only on `scl_fall`.
- **START, any state:** go to ADDR and clear the bit counter. This covers repeated START.
- **STOP, any state:** go to IDLE, release `sda`, deassert `busy`.
- **ADDR:** after 8 bits, if `addr[7:1]==SLAVE_ADDR` go to ADDR_ACK and drive `sda` low for the 9th bit. Otherwise go to WAIT_STOP with `sda` released.
- **Write transaction (R/W=0):**
  - First byte after ADDR_ACK goes to PTR. If `ptr < REG_DEPTH`, ACK and load the pointer.
  - If `ptr >= REG_DEPTH`, NACK and go to WAIT_STOP.
  - Each subsequent byte: write `regs[ptr]`, pulse `wr_strobe`, ACK, then `ptr <= (ptr==REG_DEPTH-1) ? 0 : ptr+1`.
- **Read transaction (R/W=1):**
  - After ADDR_ACK, shift out `regs[ptr]`. The byte is latched into the shift register on the `scl_fall` ending the ACK bit.
  - In RDATA_ACK, sample the master's ACK. ACK (0): increment/wrap `ptr` and load the next byte. NACK (1): release `sda` and go to WAIT_STOP.
- **Pointer retention:** the pointer persists across transactions until reset, so a write-pointer-only followed by a repeated-START read returns `regs[ptr]`.
- **Write collisions:**
  - I2C write commits on the `scl_rise` of bit 8 (the LSB).
  - `host_we` to a different register in the same cycle: both writes commit.
  - Same register in the same cycle: the I2C write wins. `wr_strobe` still pulses.
- **Reset values:**
  - all `regs` 0, `ptr` 0, state IDLE
  - `sda` released (z), `wr_strobe` 0, `wr_addr` 0, `wr_data` 0, `busy` 0

## Timing
- **Clock ratio:** requires `f_clk >= 16 * f_scl`. START/STOP hold and setup must each be ≥ 4 clk.
- **Pin-to-event latency:** `SYNC_STAGES+1` clk from an `scl` pin edge to the internal event.
- **SDA output update:** the `sda` drive register updates 1 clk after `scl_fall`. Pin-to-pin that is `SYNC_STAGES+2` clk, well inside tHD;DAT for the required ratio.
- **Write strobe:** `wr_strobe` asserts 1 clk after the `scl_rise` event that samples the data LSB. `regs` reflect the new value on the same edge.
- **Host port:** `host_rdata` has zero latency. A `host_we` write is visible on the next clk, and is visible to an I2C read if it lands before that byte's load point.
- **Reset:** `nRst` low for one `clk` edge mid-transfer aborts immediately. `sda` is released on that edge, and the block ignores the bus until the next START.

## Test plan
- **Write burst:** START, 0x84, 0x03, 0xAA, 0xBB, STOP → ACK on all four bytes; `regs[3]=0xAA`, `regs[4]=0xBB`; two `wr_strobe` pulses with `wr_addr` 3 then 4.
- **Wrap and read-back:** write ptr 0x0F, data 0x11, 0x22 (REG_DEPTH=16) → `regs[15]=0x11`, `regs[0]=0x22`. Then Sr, 0x85, read 2 bytes (ACK, NACK) after setting ptr 0x0F → reads 0x11, 0x22.
- **Address mismatch:** START, 0x90, 0x00, STOP → `sda` never driven low, no `wr_strobe`, `busy` stays 0. A following valid transaction succeeds.
- **Bad pointer:** START, 0x84, 0x20 → NACK on the pointer byte, next byte ignored, `regs` unchanged.
- **Host collision:** `host_we` to reg 5 with 0x55 in the same cycle as an I2C commit of 0x66 to reg 5 → `regs[5]=0x66`. Same test against reg 6 → both regs updated.
- **Reset mid-read:** assert `nRst` while the block is driving bit 3 of a read byte → `sda`=z next clk; all `regs` 0 and `ptr` 0 afterwards. The next START with 0x85 returns 0x00.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// -----------------------------------------------------------------------------
// i2c_slave_regfile
//
// I2C target with a built-in register file. The block oversamples scl/sda with
// the system clock, detects START, repeated START and STOP, and ACKs the 7-bit
// address SLAVE_ADDR. Write transactions load a register pointer from the first
// data byte and then store auto-incrementing bytes. Read transactions shift out
// regs[ptr] with auto-increment while the master ACKs. A host port gives
// on-chip logic direct access to the same registers.
//
// Ports
//   clk        system clock (scl is sampled, never used as a clock)
//   nRst       synchronous active-low reset
//   scl        I2C clock pin (no clock stretching)
//   sda        I2C data pin, open-drain: driven 1'b0 or released (z)
//   host_we    host write strobe
//   host_addr  host register index
//   host_wdata host write data
//   host_rdata combinational read of regs[host_addr]
//   wr_strobe  one-cycle pulse when an I2C data byte is committed
//   wr_addr    register index of the committed byte
//   wr_data    committed byte
//   busy       high from an address-matched ACK until STOP or NACK termination
// -----------------------------------------------------------------------------
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         REG_DEPTH   = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PTR_W       = $clog2(REG_DEPTH)
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             scl,
  inout  wire              sda,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  localparam logic [8:0]       DEPTH9   = 9'(REG_DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(REG_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_q, sda_q;
  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [7:0]       regs [REG_DEPTH];
  // Only bits 6..0 are stored: bit 7 of a read byte is already on the pin
  // when the byte is loaded, and a received byte is completed by sda_s.
  logic [6:0]       shift;
  logic [2:0]       bit_cnt;
  logic             byte_done;
  logic             rw;
  logic             ack_ok;
  logic [PTR_W-1:0] ptr;
  logic             oe, oe_next, busy_next;

  logic [7:0]       rx_byte;
  logic [7:0]       rd_byte;
  logic [PTR_W-1:0] ptr_inc;
  logic             last_bit, addr_hit, ptr_ok, host_hit;

  assign sda = oe ? 1'b0 : 1'bz;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Bus events are derived from the synchronised pins and their previous value.
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  assign rx_byte  = {shift, sda_s};
  assign rd_byte  = regs[ptr];
  assign last_bit = scl_rise & (bit_cnt == 3'd7);
  assign addr_hit = (rx_byte[7:1] == SLAVE_ADDR);
  assign ptr_ok   = ({1'b0, rx_byte} < DEPTH9);
  assign ptr_inc  = (ptr == LAST_IDX) ? {PTR_W{1'b0}} : ptr + PTR_ONE;
  assign host_hit = (32'(host_addr) < REG_DEPTH);

  assign host_rdata = host_hit ? regs[host_addr] : 8'h00;

  // Pin synchronisers plus one edge-detect stage; idle bus level is high.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      scl_sync <= {SYNC_STAGES{1'b1}};
      sda_sync <= {SYNC_STAGES{1'b1}};
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  // State, sda drive and busy registers.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state <= IDLE;
      oe    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      oe    <= oe_next;
      busy  <= busy_next;
    end
  end

  // Next-state, next sda drive and next busy; sda only changes on scl_fall.
  always_comb begin
    state_next = state;
    oe_next    = oe;
    busy_next  = busy;
    if (start_det) begin
      state_next = ADDR;
      oe_next    = 1'b0;
    end else if (stop_det) begin
      state_next = IDLE;
      oe_next    = 1'b0;
      busy_next  = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (last_bit && !addr_hit) begin
            state_next = WAIT_STOP;
            busy_next  = 1'b0;
          end else if (scl_fall && byte_done) begin
            state_next = ADDR_ACK;
            oe_next    = 1'b1;
            busy_next  = 1'b1;
          end else begin
            state_next = ADDR;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw) begin
              state_next = RDATA;
              oe_next    = ~rd_byte[7];
            end else begin
              state_next = PTR;
              oe_next    = 1'b0;
            end
          end else begin
            state_next = ADDR_ACK;
          end
        end
        PTR: begin
          if (last_bit && !ptr_ok) begin
            state_next = WAIT_STOP;
            busy_next  = 1'b0;
          end else if (scl_fall && byte_done) begin
            state_next = PTR_ACK;
            oe_next    = 1'b1;
          end else begin
            state_next = PTR;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_next = WDATA;
            oe_next    = 1'b0;
          end else begin
            state_next = state;
          end
        end
        WDATA: begin
          if (scl_fall && byte_done) begin
            state_next = WDATA_ACK;
            oe_next    = 1'b1;
          end else begin
            state_next = WDATA;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (byte_done) begin
              state_next = RDATA_ACK;
              oe_next    = 1'b0;
            end else begin
              oe_next    = ~shift[6];
            end
          end else begin
            state_next = RDATA;
          end
        end
        RDATA_ACK: begin
          // ptr was already advanced on the ACK rise, so rd_byte is the next byte.
          if (scl_fall) begin
            if (ack_ok) begin
              state_next = RDATA;
              oe_next    = ~rd_byte[7];
            end else begin
              state_next = WAIT_STOP;
              busy_next  = 1'b0;
            end
          end else begin
            state_next = RDATA_ACK;
          end
        end
        IDLE, WAIT_STOP: begin
          state_next = state;
        end
        default: begin
          state_next = IDLE;
          oe_next    = 1'b0;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  // Datapath: bit counter, shift register, pointer, register file, write port.
  // The host write is placed first so a same-register I2C commit overrides it.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= 8'h00;
      shift     <= 7'h00;
      bit_cnt   <= 3'd0;
      byte_done <= 1'b0;
      rw        <= 1'b0;
      ack_ok    <= 1'b0;
      ptr       <= {PTR_W{1'b0}};
      wr_strobe <= 1'b0;
      wr_addr   <= {PTR_W{1'b0}};
      wr_data   <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (host_we && host_hit) regs[host_addr] <= host_wdata;
      if (start_det || stop_det) begin
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw        <= rx_byte[0];
                byte_done <= addr_hit;
              end
            end else if (scl_fall) begin
              byte_done <= 1'b0;
            end
          end
          PTR: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7 && ptr_ok) begin
                ptr       <= rx_byte[PTR_W-1:0];
                byte_done <= 1'b1;
              end
            end else if (scl_fall) begin
              byte_done <= 1'b0;
            end
          end
          WDATA: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                regs[ptr] <= rx_byte;
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
                ptr       <= ptr_inc;
                byte_done <= 1'b1;
              end
            end else if (scl_fall) begin
              byte_done <= 1'b0;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              shift   <= rd_byte[6:0];
              bit_cnt <= 3'd0;
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) byte_done <= 1'b1;
            end else if (scl_fall) begin
              if (byte_done) byte_done <= 1'b0;
              else           shift     <= {shift[5:0], 1'b0};
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              ack_ok <= ~sda_s;
              if (!sda_s) ptr <= ptr_inc;
            end else if (scl_fall && ack_ok) begin
              shift <= rd_byte[6:0];
            end
          end
          default: begin
            bit_cnt <= bit_cnt;
          end
        endcase
      end
    end
  end

endmodule
